// File: rtl/vector_execute_seq_pkg.sv
// vector_execute_pkg: shared encodings for the vector execute stage
package vector_execute_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {
    FWD_OP  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_M   = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/vector_execute_seq_if.sv
// vector_execute_seq_if: operand/handshake bus between register-read, execute and memory
interface vector_execute_seq_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 6
);
  logic inValid, inReady, outValid, outReady;
  logic [DATA_WIDTH-1:0] scalarData1, scalarData2, scalarInmediate;
  logic [DATA_WIDTH*VECTOR_SIZE-1:0] vectorOperand1, vectorOperand2, forwardWB, forwardM;
  logic [2:0] aluControl;
  logic useInmediate, isScalarInstruction, isVectorScalarOperation;
  logic [1:0] data1ScalarForwardSelector, data2ScalarForwardSelector;
  logic [1:0] data1VectorForwardSelector, data2VectorForwardSelector;
  logic [DATA_WIDTH*VECTOR_SIZE-1:0] out, dataToWrite;
  logic N, Z, V, C, busy;
  modport slave (
    input inValid, outReady, scalarData1, scalarData2, scalarInmediate,
          vectorOperand1, vectorOperand2, forwardWB, forwardM, aluControl,
          useInmediate, isScalarInstruction, isVectorScalarOperation,
          data1ScalarForwardSelector, data2ScalarForwardSelector,
          data1VectorForwardSelector, data2VectorForwardSelector,
    output inReady, outValid, out, dataToWrite, N, Z, V, C, busy
  );
  modport master (
    output inValid, outReady, scalarData1, scalarData2, scalarInmediate,
           vectorOperand1, vectorOperand2, forwardWB, forwardM, aluControl,
           useInmediate, isScalarInstruction, isVectorScalarOperation,
           data1ScalarForwardSelector, data2ScalarForwardSelector,
           data1VectorForwardSelector, data2VectorForwardSelector,
    input  inReady, outValid, out, dataToWrite, N, Z, V, C, busy
  );
endinterface

// File: rtl/vector_execute_seq_alu_lane.sv
// alu_lane: one element operation with N/Z/V/C flags
module alu_lane import vector_execute_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_e               op,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  n,
  output logic                  z,
  output logic                  v,
  output logic                  c
);
  localparam int M = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] W = DATA_WIDTH'(DATA_WIDTH);
  logic [DATA_WIDTH:0] sum, dif;
  logic [DATA_WIDTH-1:0] sh;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign sh  = b % W;
  assign y = op == ALU_ADD ? sum[M:0] :
             op == ALU_SUB ? dif[M:0] :
             op == ALU_AND ? a & b :
             op == ALU_OR  ? a | b :
             op == ALU_XOR ? a ^ b :
             op == ALU_SHL ? a << sh :
             op == ALU_SHR ? a >> sh : b;
  assign n = y[M];
  assign z = y == '0;
  assign c = op == ALU_ADD ? sum[DATA_WIDTH] : op == ALU_SUB ? ~dif[DATA_WIDTH] : 1'b0;
  assign v = op == ALU_ADD ? (a[M] == b[M]) && (y[M] != a[M]) :
             op == ALU_SUB ? (a[M] != b[M]) && (y[M] != a[M]) : 1'b0;
endmodule

// File: rtl/vector_execute_seq.sv
// vector_execute_seq: multi-cycle execute stage, scalar in one cycle, vectors in VECTOR_SIZE/LANES groups
module vector_execute_seq import vector_execute_pkg::*; #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 6,
  parameter int LANES       = 2
) (
  input logic clk,
  input logic reset,
  vector_execute_seq_if.slave bus
);
  localparam int G  = VECTOR_SIZE / LANES;
  localparam int GW = $clog2(G) + 1;
  localparam int W  = DATA_WIDTH * VECTOR_SIZE;
  localparam int LW = DATA_WIDTH * LANES;
  if (VECTOR_SIZE % LANES != 0) begin : g_badLanes
    $error("LANES must divide VECTOR_SIZE");
  end
  state_e state, nextState;
  logic [GW-1:0] grp;
  logic [W-1:0] aReg, bReg, vA, vB, vB2, outReg, dtwReg;
  alu_op_e opReg, op;
  logic [DATA_WIDTH-1:0] sA, sB2, sB, sY;
  logic [3:0] sFlags, flags;
  logic [LW-1:0] laneY;
  logic [LANES-1:0][3:0] unusedFlags;
  logic accept;
  assign op  = alu_op_e'(bus.aluControl);
  assign sA  = bus.data1ScalarForwardSelector == FWD_WB ? bus.forwardWB[DATA_WIDTH-1:0] :
               bus.data1ScalarForwardSelector == FWD_M  ? bus.forwardM[DATA_WIDTH-1:0] : bus.scalarData1;
  assign sB2 = bus.data2ScalarForwardSelector == FWD_WB ? bus.forwardWB[DATA_WIDTH-1:0] :
               bus.data2ScalarForwardSelector == FWD_M  ? bus.forwardM[DATA_WIDTH-1:0] : bus.scalarData2;
  assign sB  = bus.useInmediate ? bus.scalarInmediate : sB2;
  assign vA  = bus.data1VectorForwardSelector == FWD_WB ? bus.forwardWB :
               bus.data1VectorForwardSelector == FWD_M  ? bus.forwardM : bus.vectorOperand1;
  assign vB2 = bus.data2VectorForwardSelector == FWD_WB ? bus.forwardWB :
               bus.data2VectorForwardSelector == FWD_M  ? bus.forwardM : bus.vectorOperand2;
  assign vB  = bus.isVectorScalarOperation ? {VECTOR_SIZE{sB}} : vB2;
  alu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_scalar (
    .a(sA), .b(sB), .op(op), .y(sY),
    .n(sFlags[3]), .z(sFlags[2]), .v(sFlags[1]), .c(sFlags[0])
  );
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .a(accept ? vA[i*DATA_WIDTH +: DATA_WIDTH] : aReg[(int'(grp)*LANES+i)*DATA_WIDTH +: DATA_WIDTH]),
      .b(accept ? vB[i*DATA_WIDTH +: DATA_WIDTH] : bReg[(int'(grp)*LANES+i)*DATA_WIDTH +: DATA_WIDTH]),
      .op(accept ? op : opReg),
      .y(laneY[i*DATA_WIDTH +: DATA_WIDTH]),
      .n(unusedFlags[i][3]), .z(unusedFlags[i][2]), .v(unusedFlags[i][1]), .c(unusedFlags[i][0])
    );
  end
  assign bus.outValid    = state == DONE;
  assign bus.busy        = state != IDLE;
  assign bus.out         = outReg;
  assign bus.dataToWrite = dtwReg;
  assign {bus.N, bus.Z, bus.V, bus.C} = flags;
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end
  // Handshake and next-state: DONE retires and re-accepts in the same cycle when outReady is high
  always_comb begin
    bus.inReady = state == IDLE || (state == DONE && bus.outReady);
    accept = bus.inValid && bus.inReady;
    nextState = state;
    if (accept) nextState = (bus.isScalarInstruction || G == 1) ? DONE : BUSY;
    else if (state == BUSY && grp == GW'(G - 1)) nextState = DONE;
    else if (state == DONE && bus.outReady) nextState = IDLE;
  end
  // Operand capture and result assembly, one lane group per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      grp <= '0;
      aReg <= '0;
      bReg <= '0;
      opReg <= ALU_ADD;
      outReg <= '0;
      dtwReg <= '0;
      flags <= '0;
    end else if (accept) begin
      aReg <= vA;
      bReg <= vB;
      opReg <= op;
      dtwReg <= vB2;
      grp <= bus.isScalarInstruction ? '0 : GW'(1);
      if (bus.isScalarInstruction) begin
        outReg <= W'(sY);
        flags <= sFlags;
      end else outReg[LW-1:0] <= laneY;
    end else if (state == BUSY) begin
      outReg[int'(grp)*LW +: LW] <= laneY;
      grp <= grp + GW'(1);
    end
  end
endmodule

// File: tb/tb_vector_execute_seq.sv
// tb_vector_execute_seq: directed scoreboard bench for the vector execute stage
module tb_vector_execute_seq;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [47:0] o;
    logic [47:0] d;
    logic [3:0]  f;
  } exp_t;
  exp_t q[$];
  exp_t e;
  vector_execute_seq_if #(.DATA_WIDTH(8), .VECTOR_SIZE(6)) bus ();
  vector_execute_seq #(.DATA_WIDTH(8), .VECTOR_SIZE(6), .LANES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Monitor: every retired result is compared against the oldest expectation
  always @(negedge clk) begin
    if (!reset && bus.outValid && bus.outReady) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", bus.out);
      end else begin
        e = q.pop_front();
        chk("out", bus.out, e.o);
        chk("dataToWrite", bus.dataToWrite, e.d);
        chk("flags", 48'({bus.N, bus.Z, bus.V, bus.C}), 48'(e.f));
      end
    end
  end
  task automatic issue(input logic [2:0] op, input logic scal, input logic vs, input logic imm,
                       input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] si,
                       input logic [47:0] v1, input logic [47:0] v2,
                       input logic [1:0] fs1, input logic [1:0] fs2, input logic [1:0] fv1, input logic [1:0] fv2,
                       input logic [47:0] fwb, input logic [47:0] fm, input logic oRdy,
                       input logic [47:0] eOut, input logic [47:0] eDtw, input logic [3:0] eFl, input int eLat);
    int lat;
    bit rdy;
    @(posedge clk); #1;
    bus.aluControl = op;
    bus.isScalarInstruction = scal;
    bus.isVectorScalarOperation = vs;
    bus.useInmediate = imm;
    bus.scalarData1 = s1;
    bus.scalarData2 = s2;
    bus.scalarInmediate = si;
    bus.vectorOperand1 = v1;
    bus.vectorOperand2 = v2;
    bus.data1ScalarForwardSelector = fs1;
    bus.data2ScalarForwardSelector = fs2;
    bus.data1VectorForwardSelector = fv1;
    bus.data2VectorForwardSelector = fv2;
    bus.forwardWB = fwb;
    bus.forwardM = fm;
    bus.outReady = oRdy;
    bus.inValid = 1;
    rdy = 0;
    for (int k = 0; k < 20 && !rdy; k++) begin
      @(negedge clk);
      rdy = bus.inReady;
      @(posedge clk); #1;
    end
    bus.inValid = 0;
    bus.vectorOperand1 = '1;
    bus.vectorOperand2 = '1;
    bus.forwardM = '1;
    bus.scalarInmediate = '1;
    chk("accepted", 48'(rdy), 48'(1));
    if (!rdy || eLat == 0) return;
    q.push_back('{o: eOut, d: eDtw, f: eFl});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.outValid) chk("inReady_while_busy", 48'(bus.inReady), 48'(0));
    end while (!bus.outValid && lat < 20);
    chk("latency", 48'(lat), 48'(eLat));
  endtask
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.inValid = 0;
    bus.outReady = 1;
    bus.aluControl = 0;
    bus.isScalarInstruction = 0;
    bus.isVectorScalarOperation = 0;
    bus.useInmediate = 0;
    bus.scalarData1 = 0;
    bus.scalarData2 = 0;
    bus.scalarInmediate = 0;
    bus.vectorOperand1 = 0;
    bus.vectorOperand2 = 0;
    bus.forwardWB = 0;
    bus.forwardM = 0;
    bus.data1ScalarForwardSelector = 0;
    bus.data2ScalarForwardSelector = 0;
    bus.data1VectorForwardSelector = 0;
    bus.data2VectorForwardSelector = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_out", bus.out, 48'h0);
    chk("reset_dataToWrite", bus.dataToWrite, 48'h0);
    chk("reset_flags", 48'({bus.N, bus.Z, bus.V, bus.C}), 48'h0);
    chk("reset_outValid", 48'(bus.outValid), 48'(0));
    chk("reset_inReady", 48'(bus.inReady), 48'(1));
    chk("reset_busy", 48'(bus.busy), 48'(0));
    // scalar add 0x7F+0x01: signed overflow into negative
    issue(3'b000, 1, 0, 0, 8'h7F, 8'h01, 8'h00, 48'h0, 48'h0, 2'b00, 2'b00, 2'b00, 2'b00,
          48'h0, 48'h0, 1, 48'h80, 48'h0, 4'b1010, 1);
    // vector sub with op1 from M stage, flags untouched
    issue(3'b001, 0, 0, 0, 8'h00, 8'h00, 8'h00, 48'hAAAAAAAAAAAA, 48'h010101010101, 2'b00, 2'b00, 2'b10, 2'b00,
          48'h0, 48'h060504030201, 1, 48'h050403020100, 48'h010101010101, 4'b1010, 3);
    // vector-scalar add with immediate broadcast, consumer stalled
    issue(3'b000, 0, 1, 1, 8'h00, 8'h00, 8'h10, 48'h0403020100F8, 48'h090909090909, 2'b00, 2'b00, 2'b00, 2'b00,
          48'h0, 48'h0, 0, 48'h141312111008, 48'h090909090909, 4'b1010, 3);
    repeat (4) begin
      @(negedge clk);
      chk("hold_outValid", 48'(bus.outValid), 48'(1));
      chk("hold_out", bus.out, 48'h141312111008);
      chk("hold_inReady", 48'(bus.inReady), 48'(0));
    end
    // retire and accept a scalar xor in the same cycle
    issue(3'b100, 1, 0, 0, 8'hF0, 8'hFF, 8'h00, 48'h0, 48'h0, 2'b00, 2'b00, 2'b00, 2'b00,
          48'h0, 48'h0, 1, 48'h0F, 48'h0, 4'b0000, 1);
    // vector op aborted by reset during its second busy cycle
    issue(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 48'h010101010101, 48'h010101010101, 2'b00, 2'b00, 2'b00, 2'b00,
          48'h0, 48'h0, 1, 48'h0, 48'h0, 4'b0000, 0);
    @(negedge clk);
    chk("busy_during_vector", 48'(bus.busy), 48'(1));
    chk("inReady_during_vector", 48'(bus.inReady), 48'(0));
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort_outValid", 48'(bus.outValid), 48'(0));
    chk("abort_out", bus.out, 48'h0);
    chk("abort_dataToWrite", bus.dataToWrite, 48'h0);
    chk("abort_inReady", 48'(bus.inReady), 48'(1));
    chk("abort_busy", 48'(bus.busy), 48'(0));
    issue(3'b000, 1, 0, 0, 8'h03, 8'h04, 8'h00, 48'h0, 48'h0, 2'b00, 2'b00, 2'b00, 2'b00,
          48'h0, 48'h0, 1, 48'h07, 48'h0, 4'b0000, 1);
    // sub 0x80-0x01: signed overflow, no borrow
    issue(3'b001, 1, 0, 0, 8'h80, 8'h01, 8'h00, 48'h0, 48'h0, 2'b00, 2'b00, 2'b00, 2'b00,
          48'h0, 48'h0, 1, 48'h7F, 48'h0, 4'b0011, 1);
    // add 0xFF+0x01 via immediate: zero with carry
    issue(3'b000, 1, 0, 1, 8'hFF, 8'h33, 8'h01, 48'h0, 48'h0, 2'b00, 2'b00, 2'b00, 2'b00,
          48'h0, 48'h0, 1, 48'h00, 48'h0, 4'b0101, 1);
    // shl with op1 from WB, amount 9 mod 8 = 1
    issue(3'b101, 1, 0, 0, 8'h00, 8'h09, 8'h00, 48'h0, 48'h0, 2'b01, 2'b00, 2'b00, 2'b00,
          48'h000000000081, 48'h0, 1, 48'h02, 48'h0, 4'b0000, 1);
    // shr with selector 11 falling back to the operand, amount 11 mod 8 = 3
    issue(3'b110, 1, 0, 0, 8'h80, 8'h0B, 8'h00, 48'h0, 48'h0, 2'b00, 2'b11, 2'b00, 2'b00,
          48'h0, 48'h000000000007, 1, 48'h10, 48'h0, 4'b0000, 1);
    // pass immediate
    issue(3'b111, 1, 0, 1, 8'h11, 8'h22, 8'hA5, 48'h0, 48'h0, 2'b00, 2'b00, 2'b00, 2'b00,
          48'h0, 48'h0, 1, 48'hA5, 48'h0, 4'b1000, 1);
    // vector or with op2 from WB: dataToWrite carries the forwarded value
    issue(3'b011, 0, 0, 0, 8'h00, 8'h00, 8'h00, 48'h0, 48'hFFFFFFFFFFFF, 2'b00, 2'b00, 2'b00, 2'b01,
          48'h010203040506, 48'h0, 1, 48'h010203040506, 48'h010203040506, 4'b1000, 3);
    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", 48'(q.size()), 48'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_execute_seq.md
Name: vector_execute_seq

Overview:
- Multi-cycle, parametrised successor of the pipeline execute stage.
- Applies forwarding, immediate select and scalar broadcast, then captures one operation per handshake.
- Scalar ops complete in one cycle; vector ops complete over VECTOR_SIZE/LANES cycles on LANES shared ALU lanes.
- Result is held in an output register behind a valid/ready handshake. Sits between decode/register-read and the memory stage.

Parameters:
DATA_WIDTH, 8, element and scalar width in bits
VECTOR_SIZE, 6, elements per vector
LANES, 2, vector ALU lanes per cycle; must divide VECTOR_SIZE (elaboration error otherwise)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
inValid  input  1  operation offered
inReady  output  1  operation accepted when inValid&inReady
scalarData1, scalarData2, scalarInmediate  input  DATA_WIDTH  scalar operands, immediate
vectorOperand1, vectorOperand2  input  DATA_WIDTH*VECTOR_SIZE  vector operands, element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
aluControl  input  3  operation code
useInmediate, isScalarInstruction, isVectorScalarOperation  input  1  mode controls
forwardWB, forwardM  input  DATA_WIDTH*VECTOR_SIZE  forwarded data; scalar use takes bits [DATA_WIDTH-1:0]
data1ScalarForwardSelector, data2ScalarForwardSelector, data1VectorForwardSelector, data2VectorForwardSelector  input  2  00 operand, 01 WB, 10 M, 11 treated as 00
outValid  output  1  result available
outReady  input  1  consumer takes result
out  output  DATA_WIDTH*VECTOR_SIZE  result; scalar result zero-extended in element 0
dataToWrite  output  DATA_WIDTH*VECTOR_SIZE  forwarded vector operand 2, captured at accept
N, Z, V, C  output  1  registered scalar flags
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous, active-high.
- Operand preparation at accept (combinational):
  - Forward muxes per selector.
  - Scalar op2 = useInmediate ? scalarInmediate : forwarded scalarData2.
  - Vector op2 = isVectorScalarOperation ? scalar op2 replicated VECTOR_SIZE times : forwarded vector op2.
  - All prepared operands and aluControl are registered at the accept edge. Later input changes are ignored.
- ALU ops, per element, modulo 2^DATA_WIDTH:
  - 000 add, 001 sub (A-B), 010 and, 011 or, 100 xor.
  - 101 shl A by B mod DATA_WIDTH, 110 logical shr by B mod DATA_WIDTH, 111 pass B.
- Flags (scalar only):
  - N = result MSB; Z = result==0.
  - Add: C = carry-out; sub: C = no-borrow (A>=B unsigned). V = signed overflow for add/sub.
  - Logic, shift and pass ops: C=0, V=0.
  - Flags update only when a scalar op is accepted. Vector ops leave flags unchanged.
- FSM, G = VECTOR_SIZE/LANES:
  - IDLE: inReady=1. On accept:
    - Scalar: result written, flags written, go DONE.
    - Vector: group 0 (elements 0..LANES-1) written, group counter=1. Go BUSY if G>1, else DONE.
  - BUSY: inReady=0. Each cycle writes group g (elements g*LANES..g*LANES+LANES-1) and increments g. After group G-1, go DONE.
  - DONE: outValid=1; out, dataToWrite and flags stable.
    - outReady=1: result retired. If inValid is also 1, the new op is accepted the same cycle (inReady = outReady in DONE) with IDLE accept actions; otherwise go IDLE.
    - outReady=0: hold all outputs.
- Latency (accept edge to outValid high): scalar 1 cycle, vector G cycles. Throughput: 1 op per G cycles with outReady tied high.
- Reset, including mid-operation:
  - State IDLE, group counter 0; in-flight op discarded.
  - out=0, dataToWrite=0, N=Z=V=C=0, outValid=0, busy=0, inReady=1 on the next cycle.
- inValid while not ready: ignored, no capture. Group counter width is clog2(G)+1, so G=1 must be handled.

Decomposition:
- Package vector_execute_pkg: alu_op_e (3-bit op encoding), fwd_sel_e (2-bit selector encoding), state_e {IDLE, BUSY, DONE}.
- Sub-module alu_lane #(DATA_WIDTH): one element op plus N/Z/V/C. Instantiated LANES times for vector groups and once for scalar.
- Forward/immediate/broadcast muxing stays inline in the top.

Test Plan (DATA_WIDTH=8, VECTOR_SIZE=6, LANES=2, G=3):
1. Reset 2 cycles -> out=0, dataToWrite=0, flags 0, outValid=0, inReady=1, busy=0.
2. Scalar add, scalarData1=0x7F, scalarData2=0x01, selectors 00 -> one cycle later outValid=1, out=0x...0080, N=1, Z=0, V=1, C=0.
3. Vector sub, data1VectorForwardSelector=10, forwardM elements {1,2,3,4,5,6}, vectorOperand2 all 0x01 -> outValid exactly 3 cycles after accept, out elements {0,1,2,3,4,5}, inReady=0 while busy, flags unchanged from test 2.
4. Vector-scalar add, isVectorScalarOperation=1, useInmediate=1, scalarInmediate=0x10, op1 elements {0xF8,0,1,2,3,4}; vectorOperand2 = {9,9,9,9,9,9} -> out {0x08,0x10,0x11,0x12,0x13,0x14}, dataToWrite = {9,9,9,9,9,9} (forwarded vector operand 2, not the broadcast).
5. Backpressure: outReady=0 for 4 cycles in DONE -> out and outValid held, inReady=0. Then outReady=1 with inValid=1 (scalar xor 0xF0^0xFF) -> same-cycle accept, next cycle out=0x0F.
6. Reset asserted in second BUSY cycle of a vector op -> next cycle outValid=0, out=0, inReady=1. A following scalar op completes normally.
